// File: rtl/jt1943_inputs.sv
// rtl/jt1943_inputs.sv - keyboard/joystick conditioning into active-low 1943 controls
module jt1943_inputs #(
  parameter int COIN_FRAMES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joy_0,
  input  logic [15:0] joy_1,
  input  logic        LVBL,
  output logic [5:0]  joystick1,
  output logic [5:0]  joystick2,
  output logic [1:0]  start_button,
  output logic [1:0]  coin_input,
  output logic        dip_pause,
  output logic        dip_test
);

  localparam int CW = $clog2(COIN_FRAMES + 1);

  localparam int K_RIGHT  = 0;
  localparam int K_LEFT   = 1;
  localparam int K_DOWN   = 2;
  localparam int K_UP     = 3;
  localparam int K_FIRE_A = 4;
  localparam int K_FIRE_B = 5;
  localparam int K_BOMB   = 6;
  localparam int K_START1 = 7;
  localparam int K_START2 = 8;
  localparam int K_COIN   = 9;
  localparam int K_PAUSE  = 10;
  localparam int K_TEST   = 11;

  logic [11:0]        key_q, key_d;
  logic               toggle_q;
  logic               lvbl_q;
  logic               pause_q, pause_d;
  logic               pause_req_q;
  logic [1:0]         coin_req_q;
  logic [1:0][CW-1:0] cnt_q, cnt_d;

  logic [5:0]         joy1_q, joy1_d;
  logic [5:0]         joy2_q, joy2_d;
  logic [1:0]         start_q, start_d;
  logic [1:0]         coin_q, coin_d;
  logic               dip_pause_q, dip_pause_d;
  logic               dip_test_q, dip_test_d;

  logic               pause_req;
  logic [1:0]         coin_req;
  logic               lvbl_fall;
  logic               unused_bits;

  assign unused_bits = ^{ps2_key[8], joy_0[15:10], joy_1[15:10]};

  // A key event is a flip of the toggle bit relative to the last sampled value.
  always_comb begin
    key_d = key_q;
    if (ps2_key[10] != toggle_q) begin
      case (ps2_key[7:0])
        8'h75:   key_d[K_UP]     = ps2_key[9];
        8'h72:   key_d[K_DOWN]   = ps2_key[9];
        8'h6B:   key_d[K_LEFT]   = ps2_key[9];
        8'h74:   key_d[K_RIGHT]  = ps2_key[9];
        8'h05:   key_d[K_START1] = ps2_key[9];
        8'h06:   key_d[K_START2] = ps2_key[9];
        8'h04:   key_d[K_COIN]   = ps2_key[9];
        8'h0C:   key_d[K_PAUSE]  = ps2_key[9];
        8'h03:   key_d[K_TEST]   = ps2_key[9];
        8'h14:   key_d[K_FIRE_A] = ps2_key[9];
        8'h11:   key_d[K_FIRE_B] = ps2_key[9];
        8'h29:   key_d[K_BOMB]   = ps2_key[9];
        default: key_d = key_q;
      endcase
    end
  end

  always_comb begin
    joy1_d = ~{ key_q[K_BOMB] | joy_0[5],
                key_q[K_FIRE_A] | key_q[K_FIRE_B] | joy_0[4],
                key_q[K_UP]    | joy_0[3],
                key_q[K_DOWN]  | joy_0[2],
                key_q[K_LEFT]  | joy_0[1],
                key_q[K_RIGHT] | joy_0[0] };
    joy2_d  = ~joy_1[5:0];
    start_d = ~{ key_q[K_START2] | joy_0[7] | joy_1[7],
                 key_q[K_START1] | joy_0[6] | joy_1[6] };
    pause_req   = key_q[K_PAUSE] | joy_0[9] | joy_1[9];
    pause_d     = pause_q ^ (pause_req & ~pause_req_q);
    dip_pause_d = ~pause_d;
    dip_test_d  = ~key_q[K_TEST];
  end

  // Coin stretchers: load only from idle, so a held or re-pressed coin never extends a pulse.
  always_comb begin
    coin_req  = {joy_1[8], key_q[K_COIN] | joy_0[8]};
    lvbl_fall = lvbl_q & ~LVBL;
    cnt_d     = cnt_q;
    coin_d    = 2'b11;
    for (int i = 0; i < 2; i++) begin
      if (coin_req[i] && !coin_req_q[i] && cnt_q[i] == '0) begin
        cnt_d[i] = CW'(COIN_FRAMES);
      end else if (lvbl_fall && cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end
      coin_d[i] = (cnt_q[i] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q       <= '0;
      toggle_q    <= ps2_key[10];
      lvbl_q      <= LVBL;
      pause_q     <= 1'b0;
      pause_req_q <= 1'b0;
      coin_req_q  <= 2'b00;
      cnt_q       <= '0;
      joy1_q      <= '1;
      joy2_q      <= '1;
      start_q     <= '1;
      coin_q      <= '1;
      dip_pause_q <= 1'b1;
      dip_test_q  <= 1'b1;
    end else begin
      key_q       <= key_d;
      toggle_q    <= ps2_key[10];
      lvbl_q      <= LVBL;
      pause_q     <= pause_d;
      pause_req_q <= pause_req;
      coin_req_q  <= coin_req;
      cnt_q       <= cnt_d;
      joy1_q      <= joy1_d;
      joy2_q      <= joy2_d;
      start_q     <= start_d;
      coin_q      <= coin_d;
      dip_pause_q <= dip_pause_d;
      dip_test_q  <= dip_test_d;
    end
  end

  assign joystick1    = joy1_q;
  assign joystick2    = joy2_q;
  assign start_button = start_q;
  assign coin_input   = coin_q;
  assign dip_pause    = dip_pause_q;
  assign dip_test     = dip_test_q;

endmodule

// File: tb/tb_jt1943_inputs.sv
// tb/tb_jt1943_inputs.sv - scoreboard bench for jt1943_inputs
module tb_jt1943_inputs;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] ps2_key;
  logic [15:0] joy_0, joy_1;
  logic        LVBL;
  logic [5:0]  joystick1, joystick2;
  logic [1:0]  start_button, coin_input;
  logic        dip_pause, dip_test;

  jt1943_inputs #(.COIN_FRAMES(3)) dut (
    .clk(clk), .rst(rst), .ps2_key(ps2_key), .joy_0(joy_0), .joy_1(joy_1),
    .LVBL(LVBL), .joystick1(joystick1), .joystick2(joystick2),
    .start_button(start_button), .coin_input(coin_input),
    .dip_pause(dip_pause), .dip_test(dip_test)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [17:0] v;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  logic [5:0] e_j1 = '1, e_j2 = '1;
  logic [1:0] e_st = '1, e_coin = '1;
  logic       e_dp = 1'b1, e_dt = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: outputs are sampled on the falling edge and matched to the expectation due this cycle.
  always @(negedge clk) begin
    logic [17:0] act;
    act = {joystick1, joystick2, start_button, coin_input, dip_pause, dip_test};
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      tests++;
      if (q[0].cyc < cyc) begin
        fails++;
        $display("FAIL %s: check for cycle %0d missed (now %0d)", q[0].name, q[0].cyc, cyc);
      end else if (act !== q[0].v) begin
        fails++;
        $display("FAIL %s: got %b want %b (cycle %0d)", q[0].name, act, q[0].v, cyc);
      end
      void'(q.pop_front());
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input string n);
    exp_t e;
    e.cyc  = c;
    e.v    = {e_j1, e_j2, e_st, e_coin, e_dp, e_dt};
    e.name = n;
    q.push_back(e);
  endtask

  task automatic kbd(input logic [7:0] code, input logic pressed);
    ps2_key = {~ps2_key[10], pressed, 1'b0, code};
  endtask

  initial begin
    int t;
    rst = 1'b1; ps2_key = '0; joy_0 = '0; joy_1 = '0; LVBL = 1'b1;
    step(3);
    push(cyc, "reset");
    rst = 1'b0;
    step(2);

    t = cyc; kbd(8'h75, 1'b1);
    push(t + 1, "up_latency"); e_j1 = 6'b110111; push(t + 2, "up_press"); step(4);
    t = cyc; kbd(8'h75, 1'b0);
    push(t + 1, "up_hold"); e_j1 = '1; push(t + 2, "up_release"); step(4);
    t = cyc; kbd(8'h22, 1'b1); push(t + 2, "unlisted_code"); step(4);

    t = cyc; kbd(8'h14, 1'b1); e_j1 = 6'b101111; push(t + 2, "ctrl_press"); step(3);
    kbd(8'h11, 1'b1); step(3);
    t = cyc; kbd(8'h14, 1'b0); push(t + 2, "ctrl_rel_alt_held"); step(3);
    t = cyc; kbd(8'h11, 1'b0);
    push(t + 1, "alt_rel_latency"); e_j1 = '1; push(t + 2, "alt_release"); step(3);
    t = cyc; kbd(8'h29, 1'b1); e_j1 = 6'b011111; push(t + 2, "bomb_press"); step(3);
    t = cyc; kbd(8'h29, 1'b0); e_j1 = '1; push(t + 2, "bomb_release"); step(3);

    t = cyc; kbd(8'h05, 1'b1); e_st = 2'b10; push(t + 2, "kbd_start1"); step(3);
    t = cyc; joy_1[7] = 1'b1; e_st = 2'b00; push(t + 1, "both_starts"); step(2);
    t = cyc; joy_1[7] = 1'b0; kbd(8'h05, 1'b0);
    e_st = 2'b10; push(t + 1, "start2_release"); e_st = 2'b11; push(t + 2, "start1_release"); step(3);
    t = cyc; kbd(8'h03, 1'b1); e_dt = 1'b0; push(t + 2, "test_key"); step(3);
    t = cyc; kbd(8'h03, 1'b0); e_dt = 1'b1; push(t + 2, "test_release"); step(3);

    t = cyc; joy_0 = 16'h0021; joy_1 = 16'h000C;
    e_j1 = 6'b011110; e_j2 = 6'b110011; push(t + 1, "joy_dirs"); step(2);
    t = cyc; joy_0 = '0; joy_1 = '0; e_j1 = '1; e_j2 = '1; push(t + 1, "joy_clear"); step(2);

    t = cyc; joy_0[9] = 1'b1; e_dp = 1'b0;
    push(t + 1, "pause_on"); push(t + 100, "pause_held"); step(100);
    t = cyc; joy_0[9] = 1'b0; push(t + 1, "pause_req_low"); step(3);
    t = cyc; joy_0[9] = 1'b1; e_dp = 1'b1; push(t + 1, "pause_off"); step(2);
    joy_0[9] = 1'b0; step(2);

    t = cyc;
    push(t + 1, "coin1_latency"); e_coin = 2'b10;
    push(t + 2, "coin1_on"); push(t + 502, "coin1_mid"); push(t + 901, "coin1_last");
    e_coin = 2'b11; push(t + 902, "coin1_off"); push(t + 999, "coin1_single");
    for (int i = 0; i < 1000; i++) begin
      joy_0[8] = 1'b1;
      LVBL = !((i % 400) >= 100 && (i % 400) < 120);
      step(1);
    end
    joy_0[8] = 1'b0; LVBL = 1'b1; step(2);

    t = cyc;
    push(t + 1, "coin2_latency"); e_coin = 2'b01;
    push(t + 2, "coin2_load_wins"); push(t + 85, "coin2_retrigger"); push(t + 151, "coin2_last");
    e_coin = 2'b11; push(t + 152, "coin2_off"); push(t + 200, "coin2_single");
    for (int i = 0; i < 210; i++) begin
      joy_1[8] = !(i >= 70 && i < 80);
      LVBL = !(i < 10 || (i >= 50 && i < 60) || (i >= 100 && i < 110) || (i >= 150 && i < 160));
      step(1);
    end
    joy_1[8] = 1'b0; LVBL = 1'b1; step(2);

    t = cyc; joy_0[9] = 1'b1; kbd(8'h04, 1'b1);
    e_dp = 1'b0; push(t + 1, "pause_set"); e_coin = 2'b10; push(t + 3, "kbd_coin_on");
    step(1); joy_0[9] = 1'b0; step(9);
    rst = 1'b1; e_coin = 2'b11; e_dp = 1'b1; push(t + 11, "rst_mid_pulse");
    step(1);
    rst = 1'b0; ps2_key = {ps2_key[10], 1'b1, 1'b0, 8'h75};
    push(t + 12, "post_rst"); push(t + 13, "no_event_1"); push(t + 14, "no_event_2");
    step(5);

    step(3);
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL pending: got %0d unchecked want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
